// File: rtl/ab_pattern_tx.sv
// ab_pattern_tx: drives the a-then-b sequence detector with a programmable
// burst of frames. Each frame is a one-cycle pulse on a, then one on b, then
// a CHECK cycle that samples the detector's q and counts unacknowledged frames.
module ab_pattern_tx #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [GAP_W-1:0] gap,
    input  logic             q_in,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_A,
        S_SEND_B,
        S_CHECK,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [GAP_W-1:0] gap_reg_q, gap_reg_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic             done_q, done_d;

    // Next-state and datapath decode; every register holds unless a state moves it.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_reg_d   = gap_reg_q;
        gap_cnt_d   = gap_cnt_q;
        miss_d      = miss_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = count;
                    gap_reg_d   = gap;
                    miss_d      = '0;
                    if (count != '0) begin
                        state_d = S_SEND_A;
                    end else begin
                        // Empty transfer: acknowledge immediately, send nothing.
                        done_d = 1'b1;
                    end
                end
            end

            S_SEND_A: state_d = S_SEND_B;

            S_SEND_B: state_d = S_CHECK;

            S_CHECK: begin
                // The detector must be asserting q in this exact cycle.
                if (!q_in && (miss_q != '1)) begin
                    miss_d = miss_q + CNT_W'(1);
                end
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    // Last frame: no trailing gap.
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (gap_reg_q == '0) begin
                    state_d = S_SEND_A;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = gap_reg_q;
                end
            end

            S_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d = S_SEND_A;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            gap_reg_q   <= '0;
            gap_cnt_q   <= '0;
            miss_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gap_reg_q   <= gap_reg_d;
            gap_cnt_q   <= gap_cnt_d;
            miss_q      <= miss_d;
            done_q      <= done_d;
        end
    end

    // Moore outputs decoded straight from registered state, so they are glitch-free.
    assign a        = (state_q == S_SEND_A);
    assign b        = (state_q == S_SEND_B);
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign miss_cnt = miss_q;

endmodule

// File: doc/ab_pattern_tx.md
# ab_pattern_tx

Stimulus transmitter for the two-input "a-then-b" sequence detector. On a start request it emits a programmable number of frames on `a`/`b`. Each frame is `a` high for one cycle, then `b` high for the next cycle. After each frame it samples the detector's `q` in the exact cycle the detector must assert it, and counts frames that were not acknowledged. It sits in front of the detector in the test and bring-up datapath and drives the detector's `a`/`b` inputs directly.

## Interface
- `CNT_W`, default 8: width of the frame count and of the miss counter.
- `GAP_W`, default 4: width of the inter-frame idle-gap field.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `count`  in  CNT_W  number of frames to send; latched when `start` is accepted.
- `gap`  in  GAP_W  idle cycles between frames; latched when `start` is accepted.
- `q_in`  in  1  detector output, fed back for acknowledge checking.
- `a`  out  1  detector input `a`.
- `b`  out  1  detector input `b`.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `miss_cnt`  out  CNT_W  number of frames in the current or last transfer whose CHECK cycle saw `q_in`=0.

## Operation
- States: IDLE, SEND_A, SEND_B, CHECK, GAP. All outputs are Moore, decoded from registered state/flags (glitch-free).
  - `a`=1 only in SEND_A.
  - `b`=1 only in SEND_B.
  - `busy`=1 in SEND_A, SEND_B, CHECK and GAP.
- IDLE:
  - `start`=1 latches `count`→`remaining` and `gap`→`gap_reg`, and clears `miss_cnt` to 0.
  - If the latched `count`≠0, go to SEND_A.
  - If `count`=0, stay in IDLE and pulse `done` the next cycle; no frame is sent.
- SEND_A → SEND_B unconditionally.
- SEND_B → CHECK unconditionally.
- CHECK:
  - If `q_in`=0, increment `miss_cnt`; saturate at 2^CNT_W−1.
  - Decrement `remaining`.
  - If `remaining` was 1: go to IDLE and set `done` for the following cycle.
  - Else if `gap_reg`=0: go to SEND_A (back-to-back frames).
  - Else: go to GAP and load the gap counter with `gap_reg`.
- GAP: decrement the gap counter each cycle; go to SEND_A after exactly `gap_reg` cycles in GAP.
- `start` while busy is ignored; latched `count`/`gap` are unaffected.
- `start` held high in the `done` cycle (IDLE) is accepted normally.
- No gap is inserted after the last frame.
- `miss_cnt` holds its value after completion until the next accepted `start` or reset.

## Timing
- Reset (asynchronous, any state, including mid-frame):
  - State goes to IDLE.
  - `a`=0, `b`=0, `busy`=0, `done`=0, `miss_cnt`=0.
  - `remaining` and the gap counter are cleared.
- `start` sampled high at edge k (IDLE, `count`≠0): SEND_A is active in cycle k+1, with `a`=1 and `busy`=1.
- Per frame, relative to the SEND_A cycle t:
  - Cycle t: `a`=1.
  - Cycle t+1: `b`=1.
  - Cycle t+2: CHECK, `q_in` sampled.
  - This matches the detector's latency: `a` sampled at t, `b` sampled at t+1, `q` high in t+2.
- Frame period is 3 + `gap` cycles.
- Transfer length: `busy` high for exactly N·3 + (N−1)·`gap` cycles.
- `done` is high in the single cycle immediately after the last CHECK; `busy`=0 in that cycle.
- `miss_cnt` updates at the edge ending CHECK, so it is visible from the next cycle.
- `count`=0: `done` is high in cycle k+1; `busy` never rises.

## Test plan
- Reset, then `count`=3, `gap`=0, detector connected:
  - `a` pattern is 100100100 and `b` pattern is 010010010 over 9 cycles.
  - `busy` high for 9 cycles.
  - `done` pulses in cycle 10.
  - `miss_cnt`=0.
- `count`=2, `gap`=2, `q_in` tied 0:
  - `busy` high for 8 cycles.
  - `a` high in busy cycles 1 and 6.
  - `miss_cnt`=2.
  - One `done` pulse.
- `count`=0: `done` high in the cycle after `start`; `a`, `b` and `busy` stay 0.
- `start` re-pulsed during SEND_B and during GAP of a `count`=2 transfer:
  - The pulses are ignored; exactly 2 frames are sent.
  - A new `start` asserted in the `done` cycle launches the next transfer, with SEND_A in the following cycle.
- `reset` asserted asynchronously in SEND_A mid-transfer:
  - `a`, `b`, `busy` and `miss_cnt` go to 0 immediately.
  - After release, a new `count`=1 transfer behaves normally.
- `CNT_W`=2, `count`=3, `q_in`=0, repeated twice:
  - `miss_cnt`=3 after each transfer.
  - `miss_cnt` is cleared to 0 at the second accepted `start`.
  - Separately, force 4+ misses via an internal override and check `miss_cnt` saturates at 3.
